// File: rtl/scan_pkg.sv
// Shared types and default sizing for the scan chain test controller.
package scan_pkg;

  localparam int unsigned SCAN_CHAIN_LEN = 4;
  localparam int unsigned SCAN_OUT_LAT   = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } scan_state_t;

endpackage

// File: rtl/scan_phase_cnt.sv
// Loadable up-counter with terminal-count compare; times the shift-in and shift-out phases.
module scan_phase_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_c_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tc_c_o = (cnt_q == term_i);

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan test controller: loads a pattern into the chain, pulses one capture cycle,
// unloads the response and compares it with the expected vector.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = SCAN_CHAIN_LEN,
  parameter int unsigned OUT_LAT   = SCAN_OUT_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expect_in,
  input  logic                 chain_so,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] capture_data
);

  localparam int unsigned CW = $clog2(CHAIN_LEN + OUT_LAT + 1);

  scan_state_t          state_q, state_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic                 pass_q, pass_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0]        cnt, cnt_term;

  // Terminal count depends on which shift phase is running.
  assign cnt_term = (state_q == SHIFT_IN) ? CW'(CHAIN_LEN - 1)
                                          : CW'(CHAIN_LEN + OUT_LAT - 1);

  scan_phase_cnt #(
    .W (CW)
  ) u_phase_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (cnt_term),
    .cnt_o  (cnt),
    .tc_c_o (cnt_tc)
  );

  // Outputs are computed for the next cycle so the pins come straight from flops.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    exp_d     = exp_q;
    cap_d     = cap_q;
    pass_d    = pass_q;
    scan_en_d = 1'b0;
    scan_in_d = 1'b0;
    done_d    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d     = expect_in;
          cap_d     = '0;
          pass_d    = 1'b0;
          cnt_clr   = 1'b1;
          state_d   = SHIFT_IN;
          scan_en_d = 1'b1;
          scan_in_d = pattern_in[CHAIN_LEN-1];
          pat_d     = pattern_in << 1;
        end
      end
      SHIFT_IN: begin
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = CAPTURE;
        end else begin
          cnt_en    = 1'b1;
          scan_en_d = 1'b1;
          scan_in_d = pat_q[CHAIN_LEN-1];
          pat_d     = pat_q << 1;
        end
      end
      CAPTURE: begin
        cnt_clr   = 1'b1;
        state_d   = SHIFT_OUT;
        scan_en_d = 1'b1;
      end
      SHIFT_OUT: begin
        // First OUT_LAT cycles only flush the output pipeline.
        if (cnt >= CW'(OUT_LAT)) begin
          cap_d = (cap_q << 1) | CHAIN_LEN'(chain_so);
        end
        if (cnt_tc) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (cap_d == exp_q);
        end else begin
          cnt_en    = 1'b1;
          scan_en_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      exp_q     <= '0;
      cap_q     <= '0;
      pass_q    <= 1'b0;
      scan_en_q <= 1'b0;
      scan_in_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      exp_q     <= exp_d;
      cap_q     <= cap_d;
      pass_q    <= pass_d;
      scan_en_q <= scan_en_d;
      scan_in_q <= scan_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign scan_en      = scan_en_q;
  assign scan_in      = scan_in_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign capture_data = cap_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench: controller around a 4-bit scan-cell counter, plus a single-cell
// chain instance with CHAIN_LEN=1, OUT_LAT=0.
module tb_scan_chain_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start_a = 1'b0;
  logic [3:0] pattern_a = '0, expect_a = '0;
  logic       so_a, scan_en_a, scan_in_a, busy_a, done_a, pass_a;
  logic [3:0] cap_a;
  logic [3:0] cells_a;

  logic       start_b = 1'b0;
  logic [0:0] pattern_b = '0, expect_b = '0;
  logic       scan_en_b, scan_in_b, busy_b, done_b, pass_b;
  logic [0:0] cap_b;
  logic       cell_b;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  scan_chain_ctrl #(.CHAIN_LEN(4), .OUT_LAT(1)) u_dut_a (
    .clk (clk), .rst (rst), .start (start_a),
    .pattern_in (pattern_a), .expect_in (expect_a), .chain_so (so_a),
    .scan_en (scan_en_a), .scan_in (scan_in_a), .busy (busy_a),
    .done (done_a), .pass (pass_a), .capture_data (cap_a)
  );

  scan_chain_ctrl #(.CHAIN_LEN(1), .OUT_LAT(0)) u_dut_b (
    .clk (clk), .rst (rst), .start (start_b),
    .pattern_in (pattern_b), .expect_in (expect_b), .chain_so (cell_b),
    .scan_en (scan_en_b), .scan_in (scan_in_b), .busy (busy_b),
    .done (done_b), .pass (pass_b), .capture_data (cap_b)
  );

  // 4-bit counter built from scan cells, with one register stage after cell 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cells_a <= '0;
      so_a    <= 1'b0;
    end else begin
      if (scan_en_a) cells_a <= {cells_a[2:0], scan_in_a};
      else           cells_a <= cells_a + 4'd1;
      so_a <= cells_a[3];
    end
  end

  // Single cell that holds its value on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cell_b <= 1'b0;
    else if (scan_en_b) cell_b <= scan_in_b;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Start one test on the 4-bit instance and follow it for 14 cycles.
  task automatic run_a(input logic [3:0] pat, input logic [3:0] exp_v,
                       input logic [3:0] cap_exp, input logic pass_exp);
    int done_cyc = 0;
    int pulses = 0;
    logic [3:0] sin = '0;
    pattern_a = pat;
    expect_a  = exp_v;
    start_a   = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      if (n <= 4) begin
        check("shift_in_en", 32'(scan_en_a), 1);
        sin = {sin[2:0], scan_in_a};
      end
      if (n == 5) check("capture_en", 32'(scan_en_a), 0);
      if (done_a) begin
        pulses++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (n == 11) begin
        check("capture_data", 32'(cap_a), 32'(cap_exp));
        check("pass", 32'(pass_a), 32'(pass_exp));
      end
      if (n == 12) check("busy_after", 32'(busy_a), 0);
      @(negedge clk);
    end
    check("scan_in_seq", 32'(sin), 32'(pat));
    check("done_cycle", 32'(done_cyc), 11);
    check("done_pulses", 32'(pulses), 1);
  endtask

  initial begin
    int pulses;
    int done_cyc;

    repeat (2) @(negedge clk);
    check("rst_scan_en", 32'(scan_en_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_pass", 32'(pass_a), 0);
    check("rst_cap", 32'(cap_a), 0);
    rst = 1'b0;
    @(negedge clk);

    run_a(4'b0101, 4'b0110, 4'b0110, 1'b1);
    run_a(4'b0101, 4'b0111, 4'b0110, 1'b0);
    run_a(4'b1111, 4'b0000, 4'b0000, 1'b1);

    // Extra starts in cycles 3 and 11 are ignored; the one in cycle 13 runs.
    pattern_a = 4'b0101;
    expect_a  = 4'b0110;
    start_a   = 1'b1;
    @(negedge clk);
    pulses = 0;
    done_cyc = 0;
    for (int n = 1; n <= 26; n++) begin
      start_a = (n == 3) || (n == 11) || (n == 13);
      if (done_a) begin
        pulses++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (n == 12) check("busy_drop", 32'(busy_a), 0);
      if (n == 14) check("restart_busy", 32'(busy_a), 1);
      if (n == 24) begin
        check("restart_done", 32'(done_a), 1);
        check("restart_pass", 32'(pass_a), 1);
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    check("busy_first_done", 32'(done_cyc), 11);
    check("busy_pulses", 32'(pulses), 2);

    // Reset in the middle of shift-out.
    pattern_a = 4'b1110;
    expect_a  = 4'b1111;
    start_a   = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_busy", 32'(busy_a), 1);
    check("pre_rst_cap", 32'(cap_a), 32'(4'b0001));
    rst = 1'b1;
    #1;
    check("mid_rst_scan_en", 32'(scan_en_a), 0);
    check("mid_rst_busy", 32'(busy_a), 0);
    check("mid_rst_done", 32'(done_a), 0);
    check("mid_rst_pass", 32'(pass_a), 0);
    check("mid_rst_cap", 32'(cap_a), 0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_a) pulses++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done_a) pulses++;
    end
    check("rst_no_done", 32'(pulses), 0);
    run_a(4'b1110, 4'b1111, 4'b1111, 1'b1);

    // Single-cell chain, no output latency.
    pattern_b = 1'b1;
    expect_b  = 1'b1;
    start_b   = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    done_cyc = 0;
    for (int n = 1; n <= 6; n++) begin
      if (n == 1) begin
        check("b_scan_en", 32'(scan_en_b), 1);
        check("b_scan_in", 32'(scan_in_b), 1);
      end
      if (done_b && done_cyc == 0) done_cyc = n;
      if (n == 4) begin
        check("b_cap", 32'(cap_b), 1);
        check("b_pass", 32'(pass_b), 1);
      end
      @(negedge clk);
    end
    check("b_done_cycle", 32'(done_cyc), 4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
